cmt_trace_fifo: RTL

Commit-trace serializer downstream of the verification core wrapper. Takes up to four commit lanes per cycle (PC, instruction, privilege level, GPR write-back), compacts valid lanes in program order, tags each with a 64-bit sequence number and buffers them in a FIFO. Records drain one per cycle over a valid/ready port to the testbench checker or the trace dump. Overflow drops whole commit groups and is reported, never partially enqueued.

---
 rtl/cmt_trace_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cmt_trace_fifo.sv
// Commit-trace serializer: compacts up to four commit lanes per cycle into
// sequence-tagged records, buffers them, and drains one record per cycle.
module cmt_trace_fifo #(
    parameter int CWD   = 4,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               cmt,
    input  logic [3:0][1:0]          cmt_level,
    input  logic [3:0][63:0]         cmt_pc,
    input  logic [3:0][31:0]         cmt_ir,
    input  logic [3:0]               del_gprw,
    input  logic [3:0][5:0]          del_gpra,
    input  logic [3:0][63:0]         del_gprv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_seq,
    output logic [1:0]               out_level,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_ir,
    output logic                     out_gprw,
    output logic [5:0]               out_gpra,
    output logic [63:0]              out_gprv,
    output logic                     ovf,
    output logic [63:0]              drops,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [63:0] seq;
        logic [1:0]  level;
        logic [63:0] pc;
        logic [31:0] ir;
        logic        gprw;
        logic [5:0]  gpra;
        logic [63:0] gprv;
    } rec_t;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [2:0] b);
        logic [64:0] s;
        s = {1'b0, a} + 65'(b);
        return s[64] ? '1 : s[63:0];
    endfunction

    rec_t            mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [63:0]     seq_next;

    logic [3:0]      lane_en;
    logic [3:0][2:0] slot;
    logic [2:0]      n;
    logic [AW+1:0]   free;
    logic            accept;
    logic            deq;
    logic [AW-1:0]   waddr [4];
    rec_t            rec   [4];
    rec_t            head;

    // Lane compaction: each valid lane's slot is the count of valid lanes below it.
    always_comb begin
        n = '0;
        for (int i = 0; i < 4; i++) begin
            slot[i]    = n;
            lane_en[i] = (i < CWD) && cmt[i];
            if (lane_en[i]) n = n + 3'd1;
        end
    end

    assign occ    = wptr - rptr;
    assign free   = (AW+2)'(DEPTH) - (AW+2)'(occ);
    assign accept = ((AW+2)'(n) <= free);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            waddr[i]      = wptr[AW-1:0] + AW'(slot[i]);
            rec[i].seq    = seq_next + 64'(slot[i]);
            rec[i].level  = cmt_level[i];
            rec[i].pc     = cmt_pc[i];
            rec[i].ir     = cmt_ir[i];
            rec[i].gprw   = del_gprw[i];
            rec[i].gpra   = del_gprw[i] ? del_gpra[i] : '0;
            rec[i].gprv   = del_gprw[i] ? del_gprv[i] : '0;
        end
    end

    // Storage is data only; it is never reset and is masked at the output while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (accept && lane_en[i]) mem[waddr[i]] <= rec[i];
        end
    end

    assign out_valid = (wptr != rptr);
    assign deq       = out_valid & out_ready;
    assign head      = out_valid ? mem[rptr[AW-1:0]] : '0;

    assign out_seq   = head.seq;
    assign out_level = head.level;
    assign out_pc    = head.pc;
    assign out_ir    = head.ir;
    assign out_gprw  = head.gprw;
    assign out_gpra  = head.gpra;
    assign out_gprv  = head.gprv;

    // Rejected groups still consume sequence numbers so the consumer sees the gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            seq_next <= '0;
            ovf      <= 1'b0;
            drops    <= '0;
        end else begin
            if (n != 3'd0) begin
                seq_next <= seq_next + 64'(n);
                if (accept) begin
                    wptr <= wptr + (AW+1)'(n);
                end else begin
                    ovf   <= 1'b1;
                    drops <= sat_add(drops, n);
                end
            end
            if (deq) rptr <= rptr + 1'b1;
        end
    end

endmodule
